sb_trans_scheduler: RTL and testbench
=====================================

Name: sb_trans_scheduler

Overview:
Schedules sideband transactions into the SB transactions generator FSM. It collects one-cycle requests from three sources: LT link-state (LSE/CLSE), AT read command, and AT read response. It holds each request as a pending flag, arbitrates between them, and issues a one-cycle trans_sel code to the generator. It then waits for trans_sent, enforces an inter-transaction idle gap, and times out hung transactions. It sits between the control unit / SB receive logic and transactions_gen_fsm.

Parameters:
GAP_CYCLES, 10, idle sb_clk cycles inserted after trans_sent before the next issue (min 1).
TIMEOUT_CYCLES, 255, max sb_clk cycles in WAIT before abandoning a transaction (min 120).

Ports:
sb_clk  in  1  sideband clock
rst  in  1  asynchronous, active-low reset
lt_req  in  1  pulse: request LT (LSE/CLSE) transaction
at_cmd_req  in  1  pulse: request AT read command
at_rsp_req  in  1  pulse: request AT read response
disconnected_s  in  1  generator FSM is in DISCONNECT
trans_sent  in  1  generator pulse: transaction completed
trans_sel  out  3  to generator: 0 idle, 2 AT cmd, 3 AT rsp, 4 LT; nonzero for exactly one cycle per issue
lt_done  out  1  pulse: LT transaction sent
at_cmd_done  out  1  pulse: AT command sent
at_rsp_done  out  1  pulse: AT response sent
pending  out  3  {lt, at_rsp, at_cmd} pending flags
busy  out  1  high in ISSUE, WAIT, GAP
timeout_err  out  1  pulse: WAIT timed out
abort  out  1  pulse: outstanding work discarded due to disconnect

Behaviour:
- Reset: all outputs 0, pending 0, state DISC, counters 0. Reset mid-transaction returns immediately to DISC. No trans_sel is driven thereafter until a new request arrives.
- All outputs are registered.
- Pending flags:
  - A request pulse sets its flag on the next edge.
  - A request for an already-pending class is merged; no counting.
  - The flag is cleared when its transaction is granted in ISSUE.
  - A request arriving in the same cycle as its own clear wins: the flag stays set.
- States: DISC, IDLE, ISSUE, WAIT, GAP.
- DISC:
  - trans_sel 0. Request pulses are ignored; pending is held at 0.
  - Go to IDLE when disconnected_s=0.
- IDLE:
  - If disconnected_s=1, go to DISC.
  - Otherwise, if pending!=0, grant one class and go to ISSUE.
  - trans_sel equals the granted code during the single ISSUE cycle.
  - Latency: request pulse at cycle N from IDLE gives trans_sel nonzero in cycle N+2.
- Fixed priority: LT > AT rsp > AT cmd.
- ISSUE: lasts one cycle, then go to WAIT. The wait counter clears.
- WAIT:
  - The counter increments each cycle.
  - On trans_sent=1: pulse the done output of the granted class for one cycle, then go to GAP.
  - If the counter reaches TIMEOUT_CYCLES without trans_sent: pulse timeout_err, drop the transaction with no done pulse, then go to GAP.
  - trans_sent outside WAIT is ignored.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are still collected during GAP.
- Disconnect:
  - disconnected_s=1 in ISSUE, WAIT or GAP goes to DISC next edge.
  - Pulse abort if a grant was outstanding or pending!=0.
  - Clear pending. No done pulse is issued.
  - trans_sent and disconnected_s high in the same WAIT cycle: disconnect wins; no done pulse, abort pulses.
- Counters are wide enough for their parameter (clog2) and saturate; they do not wrap.

Optional Feature:
SB_SCHED_RR_EN:
- Defined: LT keeps absolute priority. AT rsp and AT cmd alternate via a round-robin pointer that toggles after each AT grant and resets so that AT rsp is favoured first.
- Undefined: strict fixed priority as above. An AT cmd may starve while AT rsp requests keep arriving.

Test Plan:
- Reset, disconnected_s=0, at_cmd_req pulse at cycle 5 -> trans_sel=2 exactly at cycle 7 for one cycle. trans_sent at cycle 100 -> at_cmd_done at 101. Next issue is possible no earlier than cycle 101+GAP_CYCLES+1.
- lt_req, at_rsp_req and at_cmd_req in the same cycle -> issue order 4, 3, 2. Each issue follows the previous trans_sent and a 10-cycle gap; pending goes 111 -> 011 -> 001 -> 000.
- No trans_sent after issue -> timeout_err pulses 255 cycles after ISSUE. No done pulse. Returns to IDLE after the gap.
- disconnected_s=1 mid-WAIT with at_rsp pending -> abort pulse, pending=000, state DISC. Requests ignored until disconnected_s=0.
- at_cmd_req re-pulsed in the same cycle as its own grant -> pending[0] stays 1 and a second trans_sel=2 follows. Duplicate pulses while pending produce only one issue.
- SB_SCHED_RR_EN defined, at_rsp_req and at_cmd_req held pulsing continuously -> trans_sel alternates 3, 2, 3, 2. Undefined -> 3, 3, 3.

Source files
------------

// File: rtl/sb_trans_scheduler_if.sv
// Handshake bundle between the sideband transaction scheduler, its requesters and the transactions generator.
interface sb_trans_scheduler_if;
  logic       lt_req;
  logic       at_cmd_req;
  logic       at_rsp_req;
  logic       disconnected_s;
  logic       trans_sent;
  logic [2:0] trans_sel;
  logic       lt_done;
  logic       at_cmd_done;
  logic       at_rsp_done;
  logic [2:0] pending;
  logic       busy;
  logic       timeout_err;
  logic       abort;

  modport master (
    output lt_req, at_cmd_req, at_rsp_req, disconnected_s, trans_sent,
    input  trans_sel, lt_done, at_cmd_done, at_rsp_done, pending, busy, timeout_err, abort
  );

  modport slave (
    input  lt_req, at_cmd_req, at_rsp_req, disconnected_s, trans_sent,
    output trans_sel, lt_done, at_cmd_done, at_rsp_done, pending, busy, timeout_err, abort
  );
endinterface

// File: rtl/sb_trans_scheduler.sv
// Sideband transaction scheduler: latches LT / AT requests, arbitrates, issues trans_sel and paces the generator.
// Build macro SB_SCHED_RR_EN: round-robin between AT rsp and AT cmd (LT keeps absolute priority).
module sb_trans_scheduler #(
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 sb_clk,
  input logic                 rst,
  sb_trans_scheduler_if.slave bus
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_SAT   = GAP_W'(GAP_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] SEL_IDLE   = 3'd0;
  localparam logic [2:0] SEL_AT_CMD = 3'd2;
  localparam logic [2:0] SEL_AT_RSP = 3'd3;
  localparam logic [2:0] SEL_LT     = 3'd4;

  typedef enum logic [2:0] {DISC, IDLE, ISSUE, WAIT, GAP} state_t;

  state_t            state;
  logic [2:0]        pending_q;
  logic [2:0]        trans_sel_q;
  logic [2:0]        grant_q;
  logic [2:0]        grant_mask;
  logic [2:0]        grant_code;
  logic [2:0]        req_vec;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lt_done_q;
  logic              at_cmd_done_q;
  logic              at_rsp_done_q;
  logic              busy_q;
  logic              timeout_q;
  logic              abort_q;
`ifdef SB_SCHED_RR_EN
  logic              rr_fav_cmd;
`endif

  // Bit order matches the pending output: {lt, at_rsp, at_cmd}.
  assign req_vec = {bus.lt_req, bus.at_rsp_req, bus.at_cmd_req};

  always_comb begin
    grant_mask = 3'b000;
    grant_code = SEL_IDLE;
    if (pending_q[2]) begin
      grant_mask = 3'b100;
      grant_code = SEL_LT;
    end
`ifdef SB_SCHED_RR_EN
    else if (pending_q[1] && pending_q[0]) begin
      if (rr_fav_cmd) begin
        grant_mask = 3'b001;
        grant_code = SEL_AT_CMD;
      end else begin
        grant_mask = 3'b010;
        grant_code = SEL_AT_RSP;
      end
    end
`endif
    else if (pending_q[1]) begin
      grant_mask = 3'b010;
      grant_code = SEL_AT_RSP;
    end else if (pending_q[0]) begin
      grant_mask = 3'b001;
      grant_code = SEL_AT_CMD;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state         <= DISC;
      pending_q     <= 3'b000;
      trans_sel_q   <= SEL_IDLE;
      grant_q       <= SEL_IDLE;
      gap_cnt       <= '0;
      wait_cnt      <= '0;
      lt_done_q     <= 1'b0;
      at_cmd_done_q <= 1'b0;
      at_rsp_done_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      abort_q       <= 1'b0;
`ifdef SB_SCHED_RR_EN
      rr_fav_cmd    <= 1'b0;
`endif
    end else begin
      trans_sel_q   <= SEL_IDLE;
      lt_done_q     <= 1'b0;
      at_cmd_done_q <= 1'b0;
      at_rsp_done_q <= 1'b0;
      timeout_q     <= 1'b0;
      abort_q       <= 1'b0;

      case (state)
        DISC: begin
          pending_q <= 3'b000;
          busy_q    <= 1'b0;
          if (!bus.disconnected_s) state <= IDLE;
        end

        IDLE: begin
          if (bus.disconnected_s) begin
            state     <= DISC;
            pending_q <= 3'b000;
            abort_q   <= |pending_q;
          end else if (|pending_q) begin
            // A same-cycle request for the granted class re-sets its flag.
            state       <= ISSUE;
            pending_q   <= (pending_q & ~grant_mask) | req_vec;
            trans_sel_q <= grant_code;
            grant_q     <= grant_code;
            wait_cnt    <= '0;
            busy_q      <= 1'b1;
`ifdef SB_SCHED_RR_EN
            if (grant_mask[1] || grant_mask[0]) rr_fav_cmd <= ~rr_fav_cmd;
`endif
          end else begin
            pending_q <= pending_q | req_vec;
          end
        end

        ISSUE: begin
          if (bus.disconnected_s) begin
            state     <= DISC;
            pending_q <= 3'b000;
            abort_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            state     <= WAIT;
            pending_q <= pending_q | req_vec;
            wait_cnt  <= wait_cnt + 1'b1;
          end
        end

        // wait_cnt counts cycles since the issue cycle, so the timeout lands TIMEOUT_CYCLES after it.
        WAIT: begin
          if (bus.disconnected_s) begin
            state     <= DISC;
            pending_q <= 3'b000;
            abort_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            pending_q <= pending_q | req_vec;
            if (bus.trans_sent) begin
              state         <= GAP;
              gap_cnt       <= '0;
              lt_done_q     <= (grant_q == SEL_LT);
              at_rsp_done_q <= (grant_q == SEL_AT_RSP);
              at_cmd_done_q <= (grant_q == SEL_AT_CMD);
            end else if (wait_cnt >= WAIT_LAST) begin
              state     <= GAP;
              gap_cnt   <= '0;
              timeout_q <= 1'b1;
            end else if (wait_cnt != WAIT_SAT) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        GAP: begin
          if (bus.disconnected_s) begin
            state     <= DISC;
            pending_q <= 3'b000;
            abort_q   <= |pending_q;
            busy_q    <= 1'b0;
          end else begin
            pending_q <= pending_q | req_vec;
            if (gap_cnt >= GAP_LAST) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else if (gap_cnt != GAP_SAT) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= DISC;
          pending_q <= 3'b000;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trans_sel   = trans_sel_q;
  assign bus.lt_done     = lt_done_q;
  assign bus.at_cmd_done = at_cmd_done_q;
  assign bus.at_rsp_done = at_rsp_done_q;
  assign bus.pending     = pending_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;
  assign bus.abort       = abort_q;

endmodule

// File: tb/tb_sb_trans_scheduler.sv
// Directed self-checking bench for sb_trans_scheduler (honours SB_SCHED_RR_EN for the arbitration test).
module tb_sb_trans_scheduler;
  localparam int GAP = 10;
  localparam int TMO = 255;

  logic sb_clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  sb_trans_scheduler_if bus();

  sb_trans_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .sb_clk(sb_clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 sb_clk = ~sb_clk;

  // Outputs are sampled 1 ns after the rising edge; inputs driven there are taken at the next edge.
  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic pulse_trans_sent();
    bus.trans_sent = 1'b1;
    step();
    bus.trans_sent = 1'b0;
  endtask

  task automatic wait_issue(output int n, output logic [2:0] sel);
    n   = 0;
    sel = 3'd0;
    while (n < 400) begin
      step();
      n++;
      if (bus.trans_sel != 3'd0) begin
        sel = bus.trans_sel;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.disconnected_s = 1'b1;
    repeat (3) step();
    vectors++;
    if (bus.trans_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d want 0", bus.trans_sel); end
    vectors++;
    if (bus.pending !== 3'b000) begin errors++; $display("[TB] FAIL reset_pending: got %b want 000", bus.pending); end
    vectors++;
    if ({bus.busy, bus.lt_done, bus.at_cmd_done, bus.at_rsp_done, bus.timeout_err, bus.abort} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b want 000000",
        {bus.busy, bus.lt_done, bus.at_cmd_done, bus.at_rsp_done, bus.timeout_err, bus.abort});
    end
    rst = 1'b1;
    step();
    bus.lt_req = 1'b1;
    step();
    bus.lt_req = 1'b0;
    step();
    vectors++;
    if (bus.pending !== 3'b000) begin errors++; $display("[TB] FAIL disc_ignore: pending %b want 000", bus.pending); end
    bus.disconnected_s = 1'b0;
    step();
    step();
    vectors++;
    if (bus.trans_sel !== 3'd0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_quiet: sel %0d busy %b want 0 0", bus.trans_sel, bus.busy);
    end
  endtask

  task automatic test_priority();
    int n;
    logic [2:0] sel;
    bus.lt_req = 1'b1; bus.at_rsp_req = 1'b1; bus.at_cmd_req = 1'b1;
    step();
    bus.lt_req = 1'b0; bus.at_rsp_req = 1'b0; bus.at_cmd_req = 1'b0;
    vectors++;
    if (bus.pending !== 3'b111) begin errors++; $display("[TB] FAIL prio_pend0: got %b want 111", bus.pending); end
    step();
    vectors++;
    if (bus.trans_sel !== 3'd4) begin errors++; $display("[TB] FAIL prio_first: got %0d want 4", bus.trans_sel); end
    vectors++;
    if (bus.pending !== 3'b011) begin errors++; $display("[TB] FAIL prio_pend1: got %b want 011", bus.pending); end
    step();
    vectors++;
    if (bus.trans_sel !== 3'd0) begin errors++; $display("[TB] FAIL prio_onecycle: got %0d want 0", bus.trans_sel); end
    pulse_trans_sent();
    vectors++;
    if ({bus.lt_done, bus.at_rsp_done, bus.at_cmd_done} !== 3'b100) begin
      errors++; $display("[TB] FAIL prio_lt_done: got %b want 100", {bus.lt_done, bus.at_rsp_done, bus.at_cmd_done});
    end
    wait_issue(n, sel);
    vectors++;
    if (n !== GAP + 1 || sel !== 3'd3) begin errors++; $display("[TB] FAIL prio_second: after %0d sel %0d want %0d sel 3", n, sel, GAP + 1); end
    vectors++;
    if (bus.pending !== 3'b001) begin errors++; $display("[TB] FAIL prio_pend2: got %b want 001", bus.pending); end
    step();
    pulse_trans_sent();
    vectors++;
    if (bus.at_rsp_done !== 1'b1) begin errors++; $display("[TB] FAIL prio_rsp_done: got %b want 1", bus.at_rsp_done); end
    wait_issue(n, sel);
    vectors++;
    if (n !== GAP + 1 || sel !== 3'd2) begin errors++; $display("[TB] FAIL prio_third: after %0d sel %0d want %0d sel 2", n, sel, GAP + 1); end
    vectors++;
    if (bus.pending !== 3'b000) begin errors++; $display("[TB] FAIL prio_pend3: got %b want 000", bus.pending); end
    step();
    pulse_trans_sent();
    vectors++;
    if (bus.at_cmd_done !== 1'b1) begin errors++; $display("[TB] FAIL prio_cmd_done: got %b want 1", bus.at_cmd_done); end
  endtask

  task automatic test_single_cmd();
    int n;
    logic [2:0] sel;
    repeat (GAP + 2) step();
    bus.at_cmd_req = 1'b1;
    step();
    bus.at_cmd_req = 1'b0;
    vectors++;
    if (bus.pending !== 3'b001 || bus.trans_sel !== 3'd0) begin
      errors++; $display("[TB] FAIL cmd_latency1: pend %b sel %0d want 001 0", bus.pending, bus.trans_sel);
    end
    step();
    vectors++;
    if (bus.trans_sel !== 3'd2) begin errors++; $display("[TB] FAIL cmd_latency2: got %0d want 2", bus.trans_sel); end
    step();
    vectors++;
    if (bus.trans_sel !== 3'd0 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL cmd_wait: sel %0d busy %b want 0 1", bus.trans_sel, bus.busy);
    end
    repeat (20) step();
    vectors++;
    if (bus.at_cmd_done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL cmd_hold: done %b busy %b want 0 1", bus.at_cmd_done, bus.busy);
    end
    pulse_trans_sent();
    vectors++;
    if (bus.at_cmd_done !== 1'b1) begin errors++; $display("[TB] FAIL cmd_done: got %b want 1", bus.at_cmd_done); end
    bus.at_cmd_req = 1'b1;
    step();
    bus.at_cmd_req = 1'b0;
    vectors++;
    if (bus.at_cmd_done !== 1'b0) begin errors++; $display("[TB] FAIL cmd_done_pulse: got %b want 0", bus.at_cmd_done); end
    wait_issue(n, sel);
    vectors++;
    if (n !== GAP || sel !== 3'd2) begin errors++; $display("[TB] FAIL cmd_gap: after %0d sel %0d want %0d sel 2", n, sel, GAP); end
    step();
    pulse_trans_sent();
  endtask

  task automatic test_timeout();
    int n;
    int count;
    logic [2:0] sel;
    logic saw_done;
    repeat (GAP + 2) step();
    bus.at_rsp_req = 1'b1;
    step();
    bus.at_rsp_req = 1'b0;
    wait_issue(n, sel);
    vectors++;
    if (n !== 1 || sel !== 3'd3) begin errors++; $display("[TB] FAIL tmo_issue: after %0d sel %0d want 1 sel 3", n, sel); end
    count = 0;
    saw_done = 1'b0;
    while (count < 400) begin
      step();
      count++;
      if (bus.at_rsp_done) saw_done = 1'b1;
      if (bus.timeout_err) break;
    end
    vectors++;
    if (count !== TMO) begin errors++; $display("[TB] FAIL tmo_latency: got %0d want %0d", count, TMO); end
    vectors++;
    if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL tmo_nodone: got %b want 0", saw_done); end
    step();
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL tmo_pulse: err %b busy %b want 0 1", bus.timeout_err, bus.busy);
    end
    repeat (GAP - 2) step();
    vectors++;
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL tmo_gap_end: busy %b want 1", bus.busy); end
    step();
    vectors++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle: busy %b want 0", bus.busy); end
  endtask

  task automatic test_disconnect();
    int n;
    logic [2:0] sel;
    logic seen;
    bus.at_cmd_req = 1'b1;
    step();
    bus.at_cmd_req = 1'b0;
    wait_issue(n, sel);
    vectors++;
    if (sel !== 3'd2) begin errors++; $display("[TB] FAIL disc_issue: got %0d want 2", sel); end
    step();
    bus.at_rsp_req = 1'b1;
    step();
    bus.at_rsp_req = 1'b0;
    vectors++;
    if (bus.pending !== 3'b010) begin errors++; $display("[TB] FAIL disc_pend: got %b want 010", bus.pending); end
    step();
    bus.disconnected_s = 1'b1;
    bus.trans_sent = 1'b1;
    step();
    bus.trans_sent = 1'b0;
    vectors++;
    if (bus.abort !== 1'b1 || bus.at_cmd_done !== 1'b0) begin
      errors++; $display("[TB] FAIL disc_abort: abort %b done %b want 1 0", bus.abort, bus.at_cmd_done);
    end
    vectors++;
    if (bus.pending !== 3'b000 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL disc_clear: pend %b busy %b want 000 0", bus.pending, bus.busy);
    end
    step();
    vectors++;
    if (bus.abort !== 1'b0) begin errors++; $display("[TB] FAIL disc_abort_pulse: got %b want 0", bus.abort); end
    bus.lt_req = 1'b1;
    step();
    bus.lt_req = 1'b0;
    step();
    vectors++;
    if (bus.pending !== 3'b000) begin errors++; $display("[TB] FAIL disc_ignore2: got %b want 000", bus.pending); end
    bus.disconnected_s = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (bus.trans_sel != 3'd0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL disc_no_issue: got %b want 0", seen); end
  endtask

  task automatic test_requeue();
    int n;
    logic [2:0] sel;
    logic seen;
    bus.at_cmd_req = 1'b1;
    step();
    step();
    bus.at_cmd_req = 1'b0;
    vectors++;
    if (bus.trans_sel !== 3'd2 || bus.pending !== 3'b001) begin
      errors++; $display("[TB] FAIL rq_keep: sel %0d pend %b want 2 001", bus.trans_sel, bus.pending);
    end
    step();
    bus.at_cmd_req = 1'b1;
    step();
    bus.at_cmd_req = 1'b0;
    step();
    bus.at_cmd_req = 1'b1;
    step();
    bus.at_cmd_req = 1'b0;
    vectors++;
    if (bus.pending !== 3'b001) begin errors++; $display("[TB] FAIL rq_merge: got %b want 001", bus.pending); end
    pulse_trans_sent();
    wait_issue(n, sel);
    vectors++;
    if (n !== GAP + 1 || sel !== 3'd2) begin errors++; $display("[TB] FAIL rq_second: after %0d sel %0d want %0d sel 2", n, sel, GAP + 1); end
    vectors++;
    if (bus.pending !== 3'b000) begin errors++; $display("[TB] FAIL rq_pend: got %b want 000", bus.pending); end
    step();
    pulse_trans_sent();
    seen = 1'b0;
    repeat (GAP + 10) begin
      step();
      if (bus.trans_sel != 3'd0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rq_single: extra issue %b want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [2:0] sel;
    logic seen;
    bus.lt_req = 1'b1;
    step();
    bus.lt_req = 1'b0;
    wait_issue(n, sel);
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.trans_sel !== 3'd0 || bus.pending !== 3'b000) begin
      errors++; $display("[TB] FAIL rstmid: busy %b sel %0d pend %b want 0 0 000", bus.busy, bus.trans_sel, bus.pending);
    end
    step();
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (bus.trans_sel != 3'd0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_quiet: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [2:0] sel;
    logic [2:0] want [3];
`ifdef SB_SCHED_RR_EN
    want[0] = 3'd3; want[1] = 3'd2; want[2] = 3'd3;
`else
    want[0] = 3'd3; want[1] = 3'd3; want[2] = 3'd3;
`endif
    bus.at_rsp_req = 1'b1;
    bus.at_cmd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_issue(n, sel);
      vectors++;
      if (sel !== want[i]) begin errors++; $display("[TB] FAIL arb_%0d: got %0d want %0d", i, sel, want[i]); end
      step();
      pulse_trans_sent();
    end
    bus.at_rsp_req = 1'b0;
    bus.at_cmd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.lt_req = 1'b0;
    bus.at_cmd_req = 1'b0;
    bus.at_rsp_req = 1'b0;
    bus.disconnected_s = 1'b1;
    bus.trans_sent = 1'b0;
    test_reset();
    test_priority();
    test_single_cmd();
    test_timeout();
    test_disconnect();
    test_requeue();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
